// File: rtl/cam_pkg.sv
// Shared definitions for the Wii IR camera poll controller: FSM states,
// I2C master command encodings and frame/init-table constants.
package cam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_CAM_RST       = 3'd1,
        ST_INIT_GAP_WAIT = 3'd2,
        ST_INIT_XFER     = 3'd3,
        ST_POLL_WAIT     = 3'd4,
        ST_PTR_XFER      = 3'd5,
        ST_RD_XFER       = 3'd6,
        ST_UPDATE        = 3'd7
    } state_t;

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_STOP  = 2'd3;

    localparam logic [7:0]  CAM_PTR_REG = 8'h36;
    localparam int unsigned FRAME_BYTES = 16;
    localparam int unsigned INIT_LEN    = 6;

    // Step numbering inside a transfer: 0 = START, 1 = address write, ...
    localparam logic [4:0] INIT_LAST_STEP = 5'd4;
    localparam logic [4:0] PTR_LAST_STEP  = 5'd3;
    localparam logic [4:0] RD_LAST_STEP   = 5'(FRAME_BYTES + 32'd2);

    // All-ones in the blob 0 bytes means the camera saw no blob.
    function automatic logic blob_present(input logic [7:0] b1,
                                          input logic [7:0] b2,
                                          input logic [7:0] b3);
        return !((b1 == 8'hFF) && (b2 == 8'hFF) && (b3 == 8'hFF));
    endfunction

endpackage

// File: rtl/cam_init_rom.sv
// Combinational camera init table: entry index to {register, value}.
module cam_init_rom (
    input  logic [2:0] idx,
    output logic [7:0] reg_addr,
    output logic [7:0] val
);

    // Table lookup; unused indices return zeros.
    always_comb begin
        reg_addr = 8'h00;
        val      = 8'h00;
        case (idx)
            3'd0:    begin reg_addr = 8'h30; val = 8'h01; end
            3'd1:    begin reg_addr = 8'h30; val = 8'h08; end
            3'd2:    begin reg_addr = 8'h06; val = 8'h90; end
            3'd3:    begin reg_addr = 8'h08; val = 8'hC0; end
            3'd4:    begin reg_addr = 8'h1A; val = 8'h40; end
            3'd5:    begin reg_addr = 8'h33; val = 8'h33; end
            default: begin reg_addr = 8'h00; val = 8'h00; end
        endcase
    end

endmodule

// File: rtl/cam_poll_ctrl.sv
// Wii IR camera sequencer: reset pulse, init writes, then periodic 16-byte
// frame reads through a byte-level I2C master; extracts blob 0 as x/y.
module cam_poll_ctrl
    import cam_pkg::*;
#(
    parameter logic [6:0]  I2C_ADDR     = 7'h58,
    parameter int unsigned RESET_CYCLES = 1000,
    parameter int unsigned INIT_GAP     = 1000,
    parameter int unsigned POLL_PERIOD  = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       cam_reset,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_op,
    output logic [7:0] cmd_data,
    input  logic       rsp_valid,
    input  logic [7:0] rsp_data,
    input  logic       rsp_nack,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       blob_valid,
    output logic       frame_strobe,
    output logic       busy,
    output logic       error
);

    state_t      state_r, state_s;
    logic [31:0] cnt_r, cnt_s;
    logic [31:0] poll_cnt_r, poll_cnt_s;
    logic [2:0]  idx_r, idx_s;
    logic [4:0]  step_r, step_s;
    logic        wait_rsp_r, wait_rsp_s;
    logic        cmd_valid_r, cmd_valid_s;
    logic [1:0]  cmd_op_r, cmd_op_s;
    logic [7:0]  cmd_data_r, cmd_data_s;
    logic [7:0]  b1_r, b1_s, b2_r, b2_s, b3_r, b3_s;
    logic [9:0]  x_r, x_s, y_r, y_s;
    logic        blob_valid_r, blob_valid_s;
    logic        frame_strobe_r, frame_strobe_s;
    logic        error_r, error_s;
    logic        cam_reset_r, cam_reset_s;
    logic        busy_r, busy_s;

    logic [7:0]  rom_reg_s, rom_val_s;
    logic [1:0]  step_op_s;
    logic [7:0]  step_data_s;
    logic [4:0]  last_step_s;
    logic        in_xfer_s, issue_s, rsp_fire_s;

    cam_init_rom u_rom (
        .idx      (idx_r),
        .reg_addr (rom_reg_s),
        .val      (rom_val_s)
    );

    // Command for the current step of the active transfer.
    always_comb begin
        step_op_s   = OP_STOP;
        step_data_s = 8'h00;
        last_step_s = 5'd0;
        case (state_r)
            ST_INIT_XFER: begin
                last_step_s = INIT_LAST_STEP;
                case (step_r)
                    5'd0:    begin step_op_s = OP_START; step_data_s = 8'h00; end
                    5'd1:    begin step_op_s = OP_WRITE; step_data_s = {I2C_ADDR, 1'b0}; end
                    5'd2:    begin step_op_s = OP_WRITE; step_data_s = rom_reg_s; end
                    5'd3:    begin step_op_s = OP_WRITE; step_data_s = rom_val_s; end
                    default: begin step_op_s = OP_STOP;  step_data_s = 8'h00; end
                endcase
            end
            ST_PTR_XFER: begin
                last_step_s = PTR_LAST_STEP;
                case (step_r)
                    5'd0:    begin step_op_s = OP_START; step_data_s = 8'h00; end
                    5'd1:    begin step_op_s = OP_WRITE; step_data_s = {I2C_ADDR, 1'b0}; end
                    5'd2:    begin step_op_s = OP_WRITE; step_data_s = CAM_PTR_REG; end
                    default: begin step_op_s = OP_STOP;  step_data_s = 8'h00; end
                endcase
            end
            ST_RD_XFER: begin
                last_step_s = RD_LAST_STEP;
                if (step_r == 5'd0) begin
                    step_op_s   = OP_START;
                    step_data_s = 8'h00;
                end else if (step_r == 5'd1) begin
                    step_op_s   = OP_WRITE;
                    step_data_s = {I2C_ADDR, 1'b1};
                end else if (step_r < RD_LAST_STEP) begin
                    // The final byte is NACKed to end the read burst.
                    step_op_s   = OP_READ;
                    step_data_s = {7'd0, (step_r == (RD_LAST_STEP - 5'd1))};
                end else begin
                    step_op_s   = OP_STOP;
                    step_data_s = 8'h00;
                end
            end
            default: begin
                step_op_s   = OP_STOP;
                step_data_s = 8'h00;
                last_step_s = 5'd0;
            end
        endcase
    end

    // Next-state, handshake, counter and output computation.
    always_comb begin
        state_s        = state_r;
        cnt_s          = cnt_r;
        poll_cnt_s     = poll_cnt_r;
        idx_s          = idx_r;
        step_s         = step_r;
        wait_rsp_s     = wait_rsp_r;
        cmd_valid_s    = cmd_valid_r;
        cmd_op_s       = cmd_op_r;
        cmd_data_s     = cmd_data_r;
        b1_s           = b1_r;
        b2_s           = b2_r;
        b3_s           = b3_r;
        x_s            = x_r;
        y_s            = y_r;
        blob_valid_s   = blob_valid_r;
        frame_strobe_s = 1'b0;
        error_s        = error_r;
        cam_reset_s    = cam_reset_r;

        in_xfer_s  = (state_r == ST_INIT_XFER) || (state_r == ST_PTR_XFER) ||
                     (state_r == ST_RD_XFER);
        issue_s    = in_xfer_s && !cmd_valid_r && !wait_rsp_r;
        rsp_fire_s = wait_rsp_r && rsp_valid;

        // One outstanding command: accept, then wait for its response.
        if (cmd_valid_r && cmd_ready) begin
            cmd_valid_s = 1'b0;
            wait_rsp_s  = 1'b1;
        end else if (rsp_fire_s) begin
            wait_rsp_s  = 1'b0;
        end else begin
            wait_rsp_s  = wait_rsp_r;
        end

        // The poll period keeps running through the transfers and wraps on overrun.
        if ((state_r == ST_POLL_WAIT) || (state_r == ST_PTR_XFER) ||
            (state_r == ST_RD_XFER) || (state_r == ST_UPDATE)) begin
            poll_cnt_s = (poll_cnt_r == (POLL_PERIOD - 32'd1)) ? 32'd0 : (poll_cnt_r + 32'd1);
        end else begin
            poll_cnt_s = poll_cnt_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s     = ST_CAM_RST;
                    cnt_s       = 32'd0;
                    idx_s       = 3'd0;
                    step_s      = 5'd0;
                    error_s     = 1'b0;
                    cam_reset_s = 1'b0;
                end else begin
                    state_s     = ST_IDLE;
                end
            end
            ST_CAM_RST: begin
                if (cnt_r == (RESET_CYCLES - 32'd1)) begin
                    state_s     = ST_INIT_GAP_WAIT;
                    cnt_s       = 32'd0;
                    idx_s       = 3'd0;
                    cam_reset_s = 1'b1;
                end else begin
                    cnt_s       = cnt_r + 32'd1;
                end
            end
            ST_INIT_GAP_WAIT: begin
                if (cnt_r == (INIT_GAP - 32'd1)) begin
                    state_s = ST_INIT_XFER;
                    cnt_s   = 32'd0;
                    step_s  = 5'd0;
                end else begin
                    cnt_s   = cnt_r + 32'd1;
                end
            end
            ST_INIT_XFER, ST_PTR_XFER, ST_RD_XFER: begin
                if (issue_s) begin
                    cmd_valid_s = 1'b1;
                    cmd_op_s    = step_op_s;
                    cmd_data_s  = step_data_s;
                end else if (rsp_fire_s) begin
                    if ((cmd_op_r == OP_WRITE) && rsp_nack) begin
                        // Close the bus and give up; the host restarts with start.
                        cmd_valid_s = 1'b1;
                        cmd_op_s    = OP_STOP;
                        cmd_data_s  = 8'h00;
                        error_s     = 1'b1;
                        state_s     = ST_IDLE;
                        step_s      = 5'd0;
                    end else begin
                        if (state_r == ST_RD_XFER) begin
                            case (step_r)
                                5'd3:    b1_s = rsp_data;
                                5'd4:    b2_s = rsp_data;
                                5'd5:    b3_s = rsp_data;
                                default: b1_s = b1_r;
                            endcase
                        end else begin
                            b1_s = b1_r;
                        end
                        if (step_r != last_step_s) begin
                            step_s = step_r + 5'd1;
                        end else begin
                            step_s = 5'd0;
                            case (state_r)
                                ST_INIT_XFER: begin
                                    if (idx_r == 3'(INIT_LEN - 32'd1)) begin
                                        state_s    = ST_POLL_WAIT;
                                        poll_cnt_s = 32'd0;
                                    end else begin
                                        state_s    = ST_INIT_GAP_WAIT;
                                        idx_s      = idx_r + 3'd1;
                                        cnt_s      = 32'd0;
                                    end
                                end
                                ST_PTR_XFER: state_s = ST_RD_XFER;
                                default: begin
                                    state_s        = ST_UPDATE;
                                    frame_strobe_s = 1'b1;
                                    blob_valid_s   = blob_present(b1_r, b2_r, b3_r);
                                    if (blob_present(b1_r, b2_r, b3_r)) begin
                                        x_s = {b3_r[5:4], b1_r};
                                        y_s = {b3_r[7:6], b2_r};
                                    end else begin
                                        x_s = x_r;
                                        y_s = y_r;
                                    end
                                end
                            endcase
                        end
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_POLL_WAIT: begin
                if (poll_cnt_r == (POLL_PERIOD - 32'd1)) begin
                    state_s    = ST_PTR_XFER;
                    step_s     = 5'd0;
                    poll_cnt_s = 32'd0;
                end else begin
                    state_s    = ST_POLL_WAIT;
                end
            end
            ST_UPDATE: state_s = ST_POLL_WAIT;
            default:   state_s = ST_IDLE;
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            cnt_r          <= 32'd0;
            poll_cnt_r     <= 32'd0;
            idx_r          <= 3'd0;
            step_r         <= 5'd0;
            wait_rsp_r     <= 1'b0;
            cmd_valid_r    <= 1'b0;
            cmd_op_r       <= 2'd0;
            cmd_data_r     <= 8'h00;
            b1_r           <= 8'h00;
            b2_r           <= 8'h00;
            b3_r           <= 8'h00;
            x_r            <= 10'd0;
            y_r            <= 10'd0;
            blob_valid_r   <= 1'b0;
            frame_strobe_r <= 1'b0;
            error_r        <= 1'b0;
            cam_reset_r    <= 1'b1;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            poll_cnt_r     <= poll_cnt_s;
            idx_r          <= idx_s;
            step_r         <= step_s;
            wait_rsp_r     <= wait_rsp_s;
            cmd_valid_r    <= cmd_valid_s;
            cmd_op_r       <= cmd_op_s;
            cmd_data_r     <= cmd_data_s;
            b1_r           <= b1_s;
            b2_r           <= b2_s;
            b3_r           <= b3_s;
            x_r            <= x_s;
            y_r            <= y_s;
            blob_valid_r   <= blob_valid_s;
            frame_strobe_r <= frame_strobe_s;
            error_r        <= error_s;
            cam_reset_r    <= cam_reset_s;
            busy_r         <= busy_s;
        end
    end

    assign cam_reset    = cam_reset_r;
    assign cmd_valid    = cmd_valid_r;
    assign cmd_op       = cmd_op_r;
    assign cmd_data     = cmd_data_r;
    assign x            = x_r;
    assign y            = y_r;
    assign blob_valid   = blob_valid_r;
    assign frame_strobe = frame_strobe_r;
    assign busy         = busy_r;
    assign error        = error_r;

endmodule
